ring_node_router: RTL and testbench
===================================

# ring_node_router

Downstream stage of the receiver queue in the ring interconnect: consumes the arbitrated word (`selected_sig`) and its write strobe (`sig_alert`), buffers accepted packets in a FIFO, and dispatches each one to the local sink, the left neighbour or the right neighbour. The dispatch decision uses the packet's destination ID and TTL field. It is the per-node "controller" that the receiver queue's write enable targets, and it closes the ring by driving the next nodes' inputs.

## Interface
- `width`, 32: packet width; the field layout below requires `width` ≥ 32.
- `depth`, 8: FIFO entries, power of two.
- `node_id`, 4'd0: this node's ring ID; ring size is 16.
- `clk` input 1: clock; all state updates on its rising edge.
- `reset_n` input 1: reset, asynchronous, active-low.
- `wr_en` input 1: packet strobe from the receiver queue (`sig_alert`).
- `in_pkt` input width: packet from the receiver queue; ignored and may be Z/X when `wr_en`=0.
- `in_src` input 2: cycler select, informational only; 00=left, 01=self, 10=right.
- `out_left`/`out_right`/`out_self` output width: registered packet per port.
- `valid_left`/`valid_right`/`valid_self` output 1: port holds a packet.
- `ready_left`/`ready_right`/`ready_self` input 1: port consumer accepts.
- `drop_full_cnt` output 8: packets dropped because the FIFO was full; saturates at 255.
- `drop_ttl_cnt` output 8: packets dropped because TTL expired; saturates at 255.

## Operation
- Packet fields: [31:28] dest ID, [27:24] src ID, [23:20] TTL, [19:0] payload.
- Enqueue: on an edge with `wr_en`=1 and FIFO not full, `in_pkt` is written. If the FIFO is full, the packet is dropped and `drop_full_cnt` increments. The full condition is evaluated on the registered count, so a same-edge pop does not free space for that write.
- Route decision on a popped packet, with d = (dest − `node_id`) mod 16 (4-bit wrap):
  - d=0 → self; the packet is forwarded unchanged, with TTL ignored.
  - d≠0 and TTL=0 → drop; `drop_ttl_cnt` increments and no port is driven.
  - 1 ≤ d ≤ 8 → right.
  - 9 ≤ d ≤ 15 → left.
  - Forwarded packets leave with TTL−1; all other bits are unchanged.
- FSM, 2 states:
  - IDLE: if the FIFO is non-empty, pop, route, and load the chosen `out_*` register. Set its valid and go to HOLD. A TTL drop pops and stays in IDLE.
  - HOLD: the active port's data and valid stay stable until its ready=1. On that edge, valid clears. If the FIFO is non-empty on the same edge, the next packet is popped and loaded (back-to-back); otherwise the FSM returns to IDLE.
- At most one valid is high at any time. Readies of inactive ports are ignored.
- Reset, at any time including mid-HOLD: FIFO empty, FSM IDLE, all valids 0, all `out_*` 0, both counters 0. An in-flight packet is discarded.

## Timing
- Latency: `wr_en` sampled at edge N → valid is high after edge N+1 when the FIFO was empty and the FSM was in IDLE.
- Throughput: 1 packet/cycle while the active port's ready is held at 1.
- Counters update on the same edge as the drop event.
- Simultaneous enqueue and pop is allowed when not full; the count is unchanged.
- Pointer wrap uses log2(`depth`)+1-bit pointers; full/empty come from the MSB comparison.

## Structure
- Package `net_pkg`:
  - Field bit positions: `DEST_HI`/`LO`, `SRC_*`, `TTL_*`.
  - `ID_W`=4, `RING_SIZE`=16.
  - Enum `route_t` {ROUTE_SELF, ROUTE_LEFT, ROUTE_RIGHT, ROUTE_DROP}.
  - FSM state enum.
- Sub-module `sync_fifo` (width, depth): ports clk, reset_n, wr, din, rd, dout, full, empty. It is reusable by other ring stages.

## Test plan
- `node_id`=3; `wr_en` with 0x3_1_5_00ABC, `ready_self`=1 → `valid_self` high after 2 edges; `out_self`=0x3150_0ABC.
- `node_id`=3; dest=5, TTL=4 → right port gets TTL=3. Dest=12 (d=9) → left port. Dest=11 (d=8) → right port.
- Dest=7, TTL=0 → no valid asserted; `drop_ttl_cnt`=1.
- `ready_right`=0, 10 packets all to the right → FIFO holds 8, plus 1 in the output register. `drop_full_cnt`=1. Releasing ready drains 9 packets in order, one per cycle.
- Assert `reset_n`=0 mid-HOLD with 3 packets queued → all valids 0 asynchronously. After release the FIFO is empty and the counters are 0.

Source files
------------

// File: rtl/net_pkg.sv
// Shared ring-packet field layout, route codes and router FSM states.
// The helper route_of turns dest/TTL into a port choice relative to a node ID.
package net_pkg;
  localparam int DEST_HI   = 31;
  localparam int DEST_LO   = 28;
  localparam int SRC_HI    = 27;
  localparam int SRC_LO    = 24;
  localparam int TTL_HI    = 23;
  localparam int TTL_LO    = 20;
  localparam int ID_W      = 4;
  localparam int RING_SIZE = 16;

  typedef enum logic [1:0] {ROUTE_SELF, ROUTE_LEFT, ROUTE_RIGHT, ROUTE_DROP} route_t;
  typedef enum logic {ST_IDLE, ST_HOLD} state_t;

  // Distance wraps modulo the 16-node ring; half the ring (d<=8) goes right.
  function automatic route_t route_of(input logic [ID_W-1:0] dest,
                                      input logic [3:0]      ttl,
                                      input logic [ID_W-1:0] nid);
    logic [ID_W-1:0] d;
    d = dest - nid;
    if (d == '0)        return ROUTE_SELF;
    else if (ttl == '0) return ROUTE_DROP;
    else if (d <= 4'd8) return ROUTE_RIGHT;
    else                return ROUTE_LEFT;
  endfunction
endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO: dout always presents the head entry.
// Extra pointer MSB distinguishes full from empty; writes when full are ignored.
module sync_fifo #(
  parameter int width = 32,
  parameter int depth = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             wr,
  input  logic [width-1:0] din,
  input  logic             rd,
  output logic [width-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(depth);

  logic [width-1:0] mem [depth];
  logic [AW:0]      wp, rp;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (wr && !full) wp <= wp + (AW+1)'(1);
      if (rd && !empty) rp <= rp + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (wr && !full) mem[wp[AW-1:0]] <= din;
  end

  assign dout  = mem[rp[AW-1:0]];
  assign empty = (wp == rp);
  assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
endmodule

// File: rtl/ring_node_router.sv
// Per-node ring router: buffers strobed packets and dispatches each to self/left/right.
// One packet held per output until its ready; full-FIFO and expired-TTL drops are counted.
module ring_node_router import net_pkg::*; #(
  parameter int              width   = 32,
  parameter int              depth   = 8,
  parameter logic [ID_W-1:0] node_id = 4'd0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             wr_en,
  input  logic [width-1:0] in_pkt,
  input  logic [1:0]       in_src,
  output logic [width-1:0] out_left,
  output logic [width-1:0] out_right,
  output logic [width-1:0] out_self,
  output logic             valid_left,
  output logic             valid_right,
  output logic             valid_self,
  input  logic             ready_left,
  input  logic             ready_right,
  input  logic             ready_self,
  output logic [7:0]       drop_full_cnt,
  output logic [7:0]       drop_ttl_cnt
);
  logic             full, empty, pop, active_rdy;
  logic [width-1:0] head, fwd;
  route_t           rt, active;
  state_t           state, next_state;

  sync_fifo #(.width(width), .depth(depth)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .wr      (wr_en && !full),
    .din     (in_pkt),
    .rd      (pop),
    .dout    (head),
    .full    (full),
    .empty   (empty)
  );

  always_comb begin
    rt  = route_of(head[DEST_HI:DEST_LO], head[TTL_HI:TTL_LO], node_id);
    fwd = head;
    if (rt != ROUTE_SELF) fwd[TTL_HI:TTL_LO] = head[TTL_HI:TTL_LO] - 4'd1;

    case (active)
      ROUTE_LEFT:  active_rdy = ready_left;
      ROUTE_RIGHT: active_rdy = ready_right;
      default:     active_rdy = ready_self;
    endcase

    pop        = 1'b0;
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          next_state = (rt == ROUTE_DROP) ? ST_IDLE : ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (active_rdy) begin
          pop        = !empty;
          next_state = (!empty && rt != ROUTE_DROP) ? ST_HOLD : ST_IDLE;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= ST_IDLE;
      active        <= ROUTE_SELF;
      valid_left    <= 1'b0;
      valid_right   <= 1'b0;
      valid_self    <= 1'b0;
      out_left      <= '0;
      out_right     <= '0;
      out_self      <= '0;
      drop_full_cnt <= '0;
      drop_ttl_cnt  <= '0;
    end else begin
      state <= next_state;
      if (state == ST_HOLD && active_rdy) begin
        valid_left  <= 1'b0;
        valid_right <= 1'b0;
        valid_self  <= 1'b0;
      end
      if (pop) begin
        if (rt != ROUTE_DROP) active <= rt;
        case (rt)
          ROUTE_SELF:  begin out_self  <= fwd; valid_self  <= 1'b1; end
          ROUTE_LEFT:  begin out_left  <= fwd; valid_left  <= 1'b1; end
          ROUTE_RIGHT: begin out_right <= fwd; valid_right <= 1'b1; end
          default: if (drop_ttl_cnt != 8'hFF) drop_ttl_cnt <= drop_ttl_cnt + 8'd1;
        endcase
      end
      // Full is the registered state: a same-edge pop does not make room.
      if (wr_en && full && drop_full_cnt != 8'hFF) drop_full_cnt <= drop_full_cnt + 8'd1;
    end
  end
endmodule

// File: tb/tb_ring_node_router.sv
// Self-checking bench for ring_node_router (node_id=3): directed scenarios plus
// randomized traffic against a queue-based reference of the routing rules.
module tb_ring_node_router;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        wr_en = 1'b0;
  logic [31:0] in_pkt = '0;
  logic [1:0]  in_src = '0;
  logic [31:0] out_left, out_right, out_self;
  logic        valid_left, valid_right, valid_self;
  logic        ready_left = 1'b0, ready_right = 1'b0, ready_self = 1'b0;
  logic [7:0]  drop_full_cnt, drop_ttl_cnt;

  int n_cmp = 0;
  int n_err = 0;

  // Reference: pending packets, the one held at an output, and drop counts.
  logic [31:0] mq[$];
  bit          m_vld;
  int          m_port;  // 0 self, 1 left, 2 right
  logic [31:0] m_dat;
  int          m_dfull, m_dttl;

  ring_node_router #(.width(32), .depth(DEPTH), .node_id(4'd3)) dut (
    .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .in_pkt(in_pkt), .in_src(in_src),
    .out_left(out_left), .out_right(out_right), .out_self(out_self),
    .valid_left(valid_left), .valid_right(valid_right), .valid_self(valid_self),
    .ready_left(ready_left), .ready_right(ready_right), .ready_self(ready_self),
    .drop_full_cnt(drop_full_cnt), .drop_ttl_cnt(drop_ttl_cnt)
  );

  always #5 clk = ~clk;

  task automatic model_clear();
    mq.delete();
    m_vld = 0; m_port = 0; m_dat = '0; m_dfull = 0; m_dttl = 0;
  endtask

  task automatic model_step(input bit w, input logic [31:0] p, input bit rl, input bit rr, input bit rs);
    bit          was_full;
    bit          take;
    logic [31:0] h;
    logic [3:0]  d;
    was_full = (mq.size() >= DEPTH);
    take = !m_vld || (m_port == 0 ? rs : (m_port == 1 ? rl : rr));
    if (take) begin
      m_vld = 0;
      if (mq.size() > 0) begin
        h = mq.pop_front();
        d = h[31:28] - 4'd3;
        if (d == 4'd0) begin
          m_vld = 1; m_port = 0; m_dat = h;
        end else if (h[23:20] == 4'd0) begin
          if (m_dttl < 255) m_dttl++;
        end else begin
          m_vld = 1; m_port = (d <= 4'd8) ? 2 : 1;
          m_dat = h; m_dat[23:20] = h[23:20] - 4'd1;
        end
      end
    end
    if (w) begin
      if (was_full) begin
        if (m_dfull < 255) m_dfull++;
      end else mq.push_back(p);
    end
  endtask

  // One clock: drive at the falling edge, step the model at the rising edge, return at the next fall.
  task automatic cycle(input bit w, input logic [31:0] p, input bit rl, input bit rr, input bit rs);
    wr_en = w; in_pkt = p; in_src = 2'($urandom_range(0, 2));
    ready_left = rl; ready_right = rr; ready_self = rs;
    @(posedge clk);
    model_step(w, p, rl, rr, rs);
    @(negedge clk);
  endtask

  task automatic do_reset();
    wr_en = 0; ready_left = 0; ready_right = 0; ready_self = 0;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    model_clear();
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if ({valid_left, valid_right, valid_self} !== 3'b000) begin
      n_err++; $display("FAIL reset_valids got %b want 000", {valid_left, valid_right, valid_self});
    end
    n_cmp++;
    if ({out_left, out_right, out_self} !== 96'h0) begin
      n_err++; $display("FAIL reset_outs got %h %h %h want 0", out_left, out_right, out_self);
    end
    n_cmp++;
    if ({drop_full_cnt, drop_ttl_cnt} !== 16'h0) begin
      n_err++; $display("FAIL reset_cnts got %0d %0d want 0 0", drop_full_cnt, drop_ttl_cnt);
    end
  endtask

  task automatic test_self();
    do_reset();
    cycle(1, 32'h3150_0ABC, 0, 0, 1);
    n_cmp++;
    if (valid_self !== 1'b0) begin
      n_err++; $display("FAIL self_early got %b want 0", valid_self);
    end
    cycle(0, 32'h0, 0, 0, 1);
    n_cmp++;
    if (valid_self !== 1'b1 || out_self !== 32'h3150_0ABC) begin
      n_err++; $display("FAIL self_pkt got v=%b %h want v=1 31500abc", valid_self, out_self);
    end
    cycle(0, 32'h0, 0, 0, 1);
    n_cmp++;
    if (valid_self !== 1'b0) begin
      n_err++; $display("FAIL self_release got %b want 0", valid_self);
    end
  endtask

  task automatic test_routes();
    do_reset();
    cycle(1, 32'h5341_2345, 1, 1, 1);
    cycle(1, 32'hC340_0001, 1, 1, 1);
    n_cmp++;
    if (valid_right !== 1'b1 || out_right !== 32'h5331_2345) begin
      n_err++; $display("FAIL route_d2 got v=%b %h want v=1 53312345", valid_right, out_right);
    end
    cycle(1, 32'hB320_00FF, 1, 1, 1);
    n_cmp++;
    if (valid_left !== 1'b1 || valid_right !== 1'b0 || out_left !== 32'hC330_0001) begin
      n_err++; $display("FAIL route_d9 got vl=%b vr=%b %h want 1 0 c3300001", valid_left, valid_right, out_left);
    end
    cycle(0, 32'h0, 1, 1, 1);
    n_cmp++;
    if (valid_right !== 1'b1 || valid_left !== 1'b0 || out_right !== 32'hB310_00FF) begin
      n_err++; $display("FAIL route_d8 got vr=%b vl=%b %h want 1 0 b31000ff", valid_right, valid_left, out_right);
    end
  endtask

  task automatic test_ttl_drop();
    do_reset();
    cycle(1, 32'h7300_1234, 1, 1, 1);
    cycle(0, 32'h0, 1, 1, 1);
    n_cmp++;
    if ({valid_left, valid_right, valid_self} !== 3'b000 || drop_ttl_cnt !== 8'd1) begin
      n_err++; $display("FAIL ttl_drop got v=%b cnt=%0d want v=000 cnt=1",
                        {valid_left, valid_right, valid_self}, drop_ttl_cnt);
    end
  endtask

  task automatic test_full();
    logic [31:0] exp;
    do_reset();
    for (int i = 0; i < 10; i++) cycle(1, {8'h53, 4'h2, 20'(i)}, 0, 0, 0);
    n_cmp++;
    if (drop_full_cnt !== 8'd1) begin
      n_err++; $display("FAIL full_drop_cnt got %0d want 1", drop_full_cnt);
    end
    for (int k = 0; k < 9; k++) begin
      exp = {8'h53, 4'h1, 20'(k)};
      n_cmp++;
      if (valid_right !== 1'b1 || out_right !== exp) begin
        n_err++; $display("FAIL full_drain[%0d] got v=%b %h want v=1 %h", k, valid_right, out_right, exp);
      end
      cycle(0, 32'h0, 0, 1, 0);
    end
    n_cmp++;
    if (valid_right !== 1'b0) begin
      n_err++; $display("FAIL full_drained got %b want 0", valid_right);
    end
  endtask

  task automatic test_reset_mid_hold();
    for (int i = 0; i < 4; i++) cycle(1, {8'h43, 4'h5, 20'(i)}, 0, 0, 0);
    cycle(1, 32'h7300_0000, 0, 0, 0);
    wr_en = 0;
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({valid_left, valid_right, valid_self} !== 3'b000 || out_right !== 32'h0) begin
      n_err++; $display("FAIL async_reset got v=%b out=%h want 000 0", {valid_left, valid_right, valid_self}, out_right);
    end
    @(negedge clk);
    model_clear();
    reset_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({drop_full_cnt, drop_ttl_cnt} !== 16'h0) begin
      n_err++; $display("FAIL post_reset_cnts got %0d %0d want 0 0", drop_full_cnt, drop_ttl_cnt);
    end
    repeat (3) cycle(0, 32'h0, 1, 1, 1);
    n_cmp++;
    if ({valid_left, valid_right, valid_self} !== 3'b000) begin
      n_err++; $display("FAIL post_reset_empty got %b want 000", {valid_left, valid_right, valid_self});
    end
  endtask

  task automatic test_saturate();
    do_reset();
    for (int i = 0; i < 262; i++) cycle(1, 32'h7300_0000, 1, 1, 1);
    repeat (2) cycle(0, 32'h0, 1, 1, 1);
    n_cmp++;
    if (drop_ttl_cnt !== 8'd255) begin
      n_err++; $display("FAIL ttl_saturate got %0d want 255", drop_ttl_cnt);
    end
  endtask

  task automatic test_random();
    bit          w, rl, rr, rs, ev_l, ev_r, ev_s;
    logic [31:0] p;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      w  = ($urandom_range(0, 9) < 6);
      p  = $urandom;
      if ($urandom_range(0, 3) == 0) p[23:20] = 4'd0;
      rl = ($urandom_range(0, 9) < 6);
      rr = ($urandom_range(0, 9) < 6);
      rs = ($urandom_range(0, 9) < 6);
      cycle(w, p, rl, rr, rs);
      ev_s = m_vld && m_port == 0;
      ev_l = m_vld && m_port == 1;
      ev_r = m_vld && m_port == 2;
      n_cmp++;
      if ({valid_left, valid_right, valid_self} !== {ev_l, ev_r, ev_s}) begin
        n_err++; $display("FAIL rand_valid c=%0d got %b want %b", c,
                          {valid_left, valid_right, valid_self}, {ev_l, ev_r, ev_s});
      end
      if (m_vld) begin
        n_cmp++;
        if ((ev_s && out_self !== m_dat) || (ev_l && out_left !== m_dat) || (ev_r && out_right !== m_dat)) begin
          n_err++; $display("FAIL rand_data c=%0d got s=%h l=%h r=%h want %h on port %0d", c,
                            out_self, out_left, out_right, m_dat, m_port);
        end
      end
      n_cmp++;
      if (drop_full_cnt !== 8'(m_dfull) || drop_ttl_cnt !== 8'(m_dttl)) begin
        n_err++; $display("FAIL rand_cnts c=%0d got %0d %0d want %0d %0d", c,
                          drop_full_cnt, drop_ttl_cnt, m_dfull, m_dttl);
      end
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_self();
    test_routes();
    test_ttl_drop();
    test_full();
    test_reset_mid_hold();
    test_saturate();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
